// File: rtl/polyphase_output_quantiser_if.sv
// AXI-Stream style sample channel used on both sides of the output quantiser.
// The master drives data, valid and last; the slave returns ready.
interface polyphase_output_quantiser_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] tdata;
  logic             tvalid;
  logic             tlast;
  logic             tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/polyphase_output_quantiser.sv
// Rounds, shifts and saturates wide polyphase filter samples to output width over a
// two-stage valid/ready pipeline, and keeps saturation and frame-length statistics.
module polyphase_output_quantiser #(
  parameter int DATA_IN_WIDTH  = 16,
  parameter int DATA_OUT_WIDTH = 12,
  parameter int SHIFT          = 4,
  parameter int FRAME_LEN      = 0,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                               clock,
  input  logic                               reset,
  polyphase_output_quantiser_if.slave        data_in,
  polyphase_output_quantiser_if.master       data_out,
  input  logic                               clear_stats,
  output logic [COUNT_WIDTH-1:0]             sat_count,
  output logic [COUNT_WIDTH-1:0]             frame_count,
  output logic                               sat_flag,
  output logic                               length_error
);

  // One guard bit so that adding the rounding constant can never overflow.
  localparam int RW = DATA_IN_WIDTH + 1;
  localparam int OW = DATA_OUT_WIDTH;
  localparam int ROUND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [RW-1:0] ROUND_C =
    (SHIFT > 0) ? ({{(RW-1){1'b0}}, 1'b1} << ROUND_POS) : {RW{1'b0}};
  localparam logic [COUNT_WIDTH-1:0] LAST_IDX_C =
    COUNT_WIDTH'((FRAME_LEN > 0) ? FRAME_LEN - 1 : 0);
  localparam bit LEN_CHECK_C = (FRAME_LEN != 0);

  // Returns {sat, q}: q clamped to the signed OW-bit range, sat set when clamping occurred.
  function automatic logic [OW:0] sat_fn(input logic [RW-1:0] v);
    logic [RW-OW:0] top;
    top = v[RW-1:OW-1];
    if ((top == {(RW-OW+1){1'b0}}) || (top == {(RW-OW+1){1'b1}})) begin
      sat_fn = {1'b0, v[OW-1:0]};
    end else if (v[RW-1]) begin
      sat_fn = {1'b1, 1'b1, {(OW-1){1'b0}}};
    end else begin
      sat_fn = {1'b1, 1'b0, {(OW-1){1'b1}}};
    end
  endfunction

  logic                   s1_valid_r, s1_last_r;
  logic [RW-1:0]          s1_data_r;
  logic                   s2_valid_r, s2_last_r, s2_sat_r;
  logic [OW-1:0]          s2_data_r;
  logic [COUNT_WIDTH-1:0] beat_idx_r;

  logic                   s2_load_s, in_ready_s, s1_accept_s, beat_s, len_bad_s;
  logic [RW-1:0]          rounded_s;
  logic signed [RW-1:0]   shifted_s;
  logic [OW:0]            sat_res_s;

  // Handshake, datapath arithmetic and frame-length judgement for the current beat.
  always_comb begin
    s2_load_s   = s1_valid_r & (~s2_valid_r | data_out.tready);
    in_ready_s  = ~reset & (~s1_valid_r | s2_load_s);
    s1_accept_s = data_in.tvalid & in_ready_s;
    rounded_s   = {data_in.tdata[DATA_IN_WIDTH-1], data_in.tdata} + ROUND_C;
    shifted_s   = $signed(s1_data_r) >>> SHIFT;
    sat_res_s   = sat_fn(shifted_s);
    beat_s      = s2_valid_r & data_out.tready;
    len_bad_s   = 1'b0;
    if (LEN_CHECK_C) begin
      if (s2_last_r) begin
        len_bad_s = (beat_idx_r != LAST_IDX_C);
      end else begin
        len_bad_s = (beat_idx_r == LAST_IDX_C);
      end
    end else begin
      len_bad_s = 1'b0;
    end
  end

  assign data_in.tready  = in_ready_s;
  assign data_out.tdata  = s2_data_r;
  assign data_out.tvalid = s2_valid_r;
  assign data_out.tlast  = s2_last_r;

  // Two-stage pipeline: S1 holds the rounded sample, S2 the saturated output beat.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_data_r  <= {RW{1'b0}};
      s2_valid_r <= 1'b0;
      s2_last_r  <= 1'b0;
      s2_sat_r   <= 1'b0;
      s2_data_r  <= {OW{1'b0}};
    end else begin
      if (s1_accept_s) begin
        s1_valid_r <= 1'b1;
        s1_data_r  <= rounded_s;
        s1_last_r  <= data_in.tlast;
      end else if (s2_load_s) begin
        s1_valid_r <= 1'b0;
      end
      if (s2_load_s) begin
        s2_valid_r <= 1'b1;
        s2_data_r  <= sat_res_s[OW-1:0];
        s2_sat_r   <= sat_res_s[OW];
        s2_last_r  <= s1_last_r;
      end else if (data_out.tready) begin
        s2_valid_r <= 1'b0;
      end
    end
  end

  // Per-beat statistics; a clear beats a coincident output beat, beat_idx keeps framing.
  always_ff @(posedge clock) begin
    if (reset) begin
      beat_idx_r   <= {COUNT_WIDTH{1'b0}};
      sat_count    <= {COUNT_WIDTH{1'b0}};
      frame_count  <= {COUNT_WIDTH{1'b0}};
      sat_flag     <= 1'b0;
      length_error <= 1'b0;
    end else begin
      if (beat_s) begin
        beat_idx_r <= s2_last_r ? {COUNT_WIDTH{1'b0}} : beat_idx_r + COUNT_WIDTH'(1);
      end
      if (clear_stats) begin
        sat_count    <= {COUNT_WIDTH{1'b0}};
        frame_count  <= {COUNT_WIDTH{1'b0}};
        sat_flag     <= 1'b0;
        length_error <= 1'b0;
      end else if (beat_s) begin
        if (s2_sat_r && (sat_count != {COUNT_WIDTH{1'b1}})) begin
          sat_count <= sat_count + COUNT_WIDTH'(1);
        end
        sat_flag <= sat_flag | s2_sat_r;
        if (s2_last_r) begin
          frame_count <= frame_count + COUNT_WIDTH'(1);
        end
        if (len_bad_s) begin
          length_error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_polyphase_output_quantiser.sv
// Directed bench for polyphase_output_quantiser (16 -> 12 bits, SHIFT 4, FRAME_LEN 4).
module tb_polyphase_output_quantiser;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        clear_stats = 1'b0;
  logic [15:0] sat_count, frame_count;
  logic        sat_flag, length_error;
  int          n_pass = 0;
  int          n_total = 0;
  bit          gen_done = 1'b0;
  logic [12:0] got_q[$];

  polyphase_output_quantiser_if #(.WIDTH(16)) in_if ();
  polyphase_output_quantiser_if #(.WIDTH(12)) out_if ();

  polyphase_output_quantiser #(
    .DATA_IN_WIDTH(16), .DATA_OUT_WIDTH(12), .SHIFT(4), .FRAME_LEN(4), .COUNT_WIDTH(16)
  ) dut (
    .clock(clock), .reset(reset), .data_in(in_if.slave), .data_out(out_if.master),
    .clear_stats(clear_stats), .sat_count(sat_count), .frame_count(frame_count),
    .sat_flag(sat_flag), .length_error(length_error)
  );

  always #5 clock = ~clock;

  // Record every completed output beat as {tlast, tdata}.
  always @(negedge clock) begin
    if (!reset && out_if.tvalid && out_if.tready) got_q.push_back({out_if.tlast, out_if.tdata});
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    int   waited;
    logic acc;
    waited = 0;
    in_if.tdata = d; in_if.tlast = l; in_if.tvalid = 1'b1;
    forever begin
      @(negedge clock);
      acc = in_if.tready;
      tick();
      if (acc) break;
      waited++;
      if (waited > 200) begin
        n_total++;
        $display("FAIL send_timeout data=%h", d);
        break;
      end
    end
    in_if.tvalid = 1'b0;
  endtask

  task automatic test_reset();
    in_if.tvalid = 1'b0; in_if.tlast = 1'b0; in_if.tdata = 16'h0000; out_if.tready = 1'b1;
    reset = 1'b1;
    tick(); tick();
    @(negedge clock);
    n_total++;
    if (in_if.tready !== 1'b0) $display("FAIL rst_tready got %b exp 0", in_if.tready); else n_pass++;
    n_total++;
    if (out_if.tvalid !== 1'b0) $display("FAIL rst_tvalid got %b exp 0", out_if.tvalid); else n_pass++;
    tick();
    reset = 1'b0;
    @(negedge clock);
    n_total++;
    if (in_if.tready !== 1'b1) $display("FAIL post_rst_tready got %b exp 1", in_if.tready); else n_pass++;
    n_total++;
    if ({sat_count, frame_count, sat_flag, length_error} !== 34'd0)
      $display("FAIL rst_stats got %h/%h/%b/%b exp 0", sat_count, frame_count, sat_flag, length_error);
    else n_pass++;
  endtask

  task automatic test_rounding();
    logic [15:0] vin[3]  = '{16'h0018, 16'hFFF8, 16'h8000};
    logic [11:0] vexp[3] = '{12'h002, 12'h000, 12'h800};
    tick();
    out_if.tready = 1'b1;
    in_if.tvalid = 1'b1; in_if.tlast = 1'b0; in_if.tdata = vin[0];
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k + 1 < 3) in_if.tdata = vin[k+1]; else in_if.tvalid = 1'b0;
      @(negedge clock);
      n_total++;
      if (k >= 1 && k <= 3) begin
        if (out_if.tvalid !== 1'b1 || out_if.tdata !== vexp[k-1])
          $display("FAIL round_%0d got v=%b d=%h exp v=1 d=%h", k, out_if.tvalid, out_if.tdata, vexp[k-1]);
        else n_pass++;
      end else begin
        if (out_if.tvalid !== 1'b0) $display("FAIL round_idle_%0d got v=%b exp 0", k, out_if.tvalid);
        else n_pass++;
      end
    end
    n_total++;
    if (sat_count !== 16'd0 || sat_flag !== 1'b0)
      $display("FAIL round_nosat got %h/%b exp 0/0", sat_count, sat_flag);
    else n_pass++;
  endtask

  task automatic test_saturation();
    tick();
    in_if.tdata = 16'h7FF8; in_if.tlast = 1'b1; in_if.tvalid = 1'b1;
    tick();
    in_if.tvalid = 1'b0;
    tick();
    @(negedge clock);
    n_total++;
    if (out_if.tvalid !== 1'b1 || out_if.tdata !== 12'h7FF || out_if.tlast !== 1'b1)
      $display("FAIL sat_data got v=%b d=%h l=%b exp 1/7ff/1", out_if.tvalid, out_if.tdata, out_if.tlast);
    else n_pass++;
    tick();
    @(negedge clock);
    n_total++;
    if (sat_count !== 16'd1 || sat_flag !== 1'b1 || frame_count !== 16'd1 || length_error !== 1'b0)
      $display("FAIL sat_stats got %h/%b/%h/%b exp 1/1/1/0", sat_count, sat_flag, frame_count, length_error);
    else n_pass++;
    tick();
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    @(negedge clock);
    n_total++;
    if (sat_count !== 16'd0 || sat_flag !== 1'b0 || frame_count !== 16'd0)
      $display("FAIL sat_clear got %h/%b/%h exp 0/0/0", sat_count, sat_flag, frame_count);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [12:0] exp3[3] = '{13'h0010, 13'h0020, 13'h0030};
    tick();
    got_q.delete();
    out_if.tready = 1'b0;
    in_if.tdata = 16'h0100; in_if.tlast = 1'b0; in_if.tvalid = 1'b1;
    @(negedge clock);
    n_total++;
    if (in_if.tready !== 1'b1) $display("FAIL bp_accept0 got %b exp 1", in_if.tready); else n_pass++;
    tick();
    in_if.tdata = 16'h0200;
    @(negedge clock);
    n_total++;
    if (in_if.tready !== 1'b1) $display("FAIL bp_accept1 got %b exp 1", in_if.tready); else n_pass++;
    tick();
    in_if.tdata = 16'h0300;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      n_total++;
      if (in_if.tready !== 1'b0) $display("FAIL bp_stall_%0d got %b exp 0", i, in_if.tready); else n_pass++;
      n_total++;
      if (out_if.tvalid !== 1'b1 || out_if.tdata !== 12'h010)
        $display("FAIL bp_hold_%0d got v=%b d=%h exp 1/010", i, out_if.tvalid, out_if.tdata);
      else n_pass++;
      tick();
    end
    out_if.tready = 1'b1;
    @(negedge clock);
    n_total++;
    if (in_if.tready !== 1'b1) $display("FAIL bp_release got %b exp 1", in_if.tready); else n_pass++;
    tick();
    in_if.tvalid = 1'b0;
    repeat (3) tick();
    @(negedge clock);
    n_total++;
    if (got_q.size() !== 3) $display("FAIL bp_count got %0d exp 3", got_q.size()); else n_pass++;
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      n_total++;
      if (got_q[i] !== exp3[i]) $display("FAIL bp_order_%0d got %h exp %h", i, got_q[i], exp3[i]);
      else n_pass++;
    end
    tick();
    send(16'h0400, 1'b1);
    repeat (3) tick();
    @(negedge clock);
    n_total++;
    if (frame_count !== 16'd1 || length_error !== 1'b0)
      $display("FAIL bp_frame got %h/%b exp 1/0", frame_count, length_error);
    else n_pass++;
  endtask

  task automatic test_frames();
    logic [12:0] exp_q[$];
    tick();
    got_q.delete();
    gen_done = 1'b0;
    for (int k = 1; k <= 12; k++) exp_q.push_back({(k % 4 == 0) ? 1'b1 : 1'b0, 12'(k)});
    fork
      begin
        for (int k = 1; k <= 12; k++) send(16'(k * 16 + 3), (k % 4 == 0) ? 1'b1 : 1'b0);
        gen_done = 1'b1;
      end
      begin
        while (!gen_done) begin
          tick();
          out_if.tready = 1'($urandom_range(0, 1));
        end
        out_if.tready = 1'b1;
      end
    join
    repeat (6) tick();
    @(negedge clock);
    n_total++;
    if (got_q.size() !== 12) $display("FAIL frm_count got %0d exp 12", got_q.size()); else n_pass++;
    for (int i = 0; i < 12 && i < got_q.size(); i++) begin
      n_total++;
      if (got_q[i] !== exp_q[i]) $display("FAIL frm_beat_%0d got %h exp %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    n_total++;
    if (frame_count !== 16'd4 || length_error !== 1'b0)
      $display("FAIL frm_stats got %h/%b exp 4/0", frame_count, length_error);
    else n_pass++;
    tick();
    send(16'h0010, 1'b0); send(16'h0020, 1'b0); send(16'h0030, 1'b1);
    repeat (4) tick();
    @(negedge clock);
    n_total++;
    if (frame_count !== 16'd5 || length_error !== 1'b1)
      $display("FAIL frm_short got %h/%b exp 5/1", frame_count, length_error);
    else n_pass++;
  endtask

  task automatic test_reset_midflight();
    tick();
    out_if.tready = 1'b1;
    send(16'h0010, 1'b0); send(16'h0020, 1'b0);
    repeat (3) tick();
    out_if.tready = 1'b0;
    send(16'h0030, 1'b0); send(16'h0040, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    n_total++;
    if (in_if.tready !== 1'b0) $display("FAIL mid_rst_tready got %b exp 0", in_if.tready); else n_pass++;
    tick();
    reset = 1'b0;
    @(negedge clock);
    n_total++;
    if (out_if.tvalid !== 1'b0) $display("FAIL mid_rst_tvalid got %b exp 0", out_if.tvalid); else n_pass++;
    n_total++;
    if ({sat_count, frame_count, sat_flag, length_error} !== 34'd0)
      $display("FAIL mid_rst_stats got %h/%h/%b/%b exp 0", sat_count, frame_count, sat_flag, length_error);
    else n_pass++;
    tick();
    got_q.delete();
    out_if.tready = 1'b1;
    for (int k = 1; k <= 4; k++) send(16'(k * 16), (k == 4) ? 1'b1 : 1'b0);
    repeat (4) tick();
    @(negedge clock);
    n_total++;
    if (got_q.size() !== 4 || got_q[0] !== 13'h0001)
      $display("FAIL mid_rst_flush got n=%0d first=%h exp 4/0001", got_q.size(), got_q.size() ? got_q[0] : 13'h0);
    else n_pass++;
    n_total++;
    if (frame_count !== 16'd1 || length_error !== 1'b0)
      $display("FAIL mid_rst_frame got %h/%b exp 1/0", frame_count, length_error);
    else n_pass++;
  endtask

  task automatic test_clear_coincident();
    tick();
    out_if.tready = 1'b0;
    send(16'h7FF8, 1'b1);
    tick();
    @(negedge clock);
    n_total++;
    if (out_if.tvalid !== 1'b1 || frame_count !== 16'd1)
      $display("FAIL clr_setup got v=%b fc=%h exp 1/1", out_if.tvalid, frame_count);
    else n_pass++;
    tick();
    clear_stats = 1'b1;
    out_if.tready = 1'b1;
    tick();
    clear_stats = 1'b0;
    @(negedge clock);
    n_total++;
    if ({sat_count, frame_count, sat_flag, length_error} !== 34'd0)
      $display("FAIL clr_wins got %h/%h/%b/%b exp 0", sat_count, frame_count, sat_flag, length_error);
    else n_pass++;
    n_total++;
    if (out_if.tvalid !== 1'b0) $display("FAIL clr_beat_taken got v=%b exp 0", out_if.tvalid); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_frames();
    test_reset_midflight();
    test_clear_coincident();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
